// File: rtl/random_matrix_filler_if.sv
// Handshake/bus bundle for random_matrix_filler. The element stream signals
// are present only when RMG_ELEM_STREAM_EN is defined.
interface random_matrix_filler_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_DIM = 5
);
    localparam int DIM_W = $clog2(MAX_DIM + 1);

    logic                               start;
    logic                               abort;
    logic [DIM_W-1:0]                   rows;
    logic [DIM_W-1:0]                   cols;
    logic [WIDTH-1:0]                   min_val;
    logic [WIDTH-1:0]                   max_val;
    logic                               seed_load;
    logic [15:0]                        seed;
    logic                               busy;
    logic                               done;
    logic                               valid;
    logic [MAX_DIM*MAX_DIM*WIDTH-1:0]   matrix_flat;
`ifdef RMG_ELEM_STREAM_EN
    logic                               elem_valid;
    logic [2*DIM_W-1:0]                 elem_idx;
    logic [WIDTH-1:0]                   elem_data;

    modport master (
        output start, abort, rows, cols, min_val, max_val, seed_load, seed,
        input  busy, done, valid, matrix_flat, elem_valid, elem_idx, elem_data
    );
    modport slave (
        input  start, abort, rows, cols, min_val, max_val, seed_load, seed,
        output busy, done, valid, matrix_flat, elem_valid, elem_idx, elem_data
    );
`else
    modport master (
        output start, abort, rows, cols, min_val, max_val, seed_load, seed,
        input  busy, done, valid, matrix_flat
    );
    modport slave (
        input  start, abort, rows, cols, min_val, max_val, seed_load, seed,
        output busy, done, valid, matrix_flat
    );
`endif
endinterface

// File: rtl/random_matrix_filler.sv
// Fills a MAX_DIM x MAX_DIM matrix with LFSR-derived values in [low,high], one
// element per cycle. Optional element stream outputs under RMG_ELEM_STREAM_EN.
module random_matrix_filler #(
    parameter int          WIDTH   = 8,
    parameter int          MAX_DIM = 5,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    random_matrix_filler_if.slave bus
);
    // state  | meaning
    // S_IDLE | waiting for start; seed_load accepted
    // S_FILL | writing one element per cycle, row-major
    localparam int DIM_W = $clog2(MAX_DIM + 1);
    localparam int MW    = MAX_DIM * MAX_DIM * WIDTH;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [DIM_W-1:0] rows_q, rows_d, cols_q, cols_d;
    logic [DIM_W-1:0] r_q, r_d, c_q, c_d;
    logic [WIDTH-1:0] low_q, low_d, high_q, high_d;
    logic [MW-1:0]    matrix_q, matrix_d;
    logic             busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [WIDTH:0]   span;
    logic [31:0]      base;
    logic             fb;
    logic             last;
`ifdef RMG_ELEM_STREAM_EN
    logic               elem_valid_q, elem_valid_d;
    logic [2*DIM_W-1:0] elem_idx_q, elem_idx_d;
    logic [WIDTH-1:0]   elem_data_q, elem_data_d;
`endif

    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d);
        if (d == '0) return DIM_W'(1);
        if (d > DIM_W'(MAX_DIM)) return DIM_W'(MAX_DIM);
        return d;
    endfunction

    // Full-range span (2**WIDTH) bypasses the modulo so every raw value maps to itself.
    function automatic logic [WIDTH-1:0] elem_value(input logic [WIDTH-1:0] raw,
                                                    input logic [WIDTH-1:0] lo,
                                                    input logic [WIDTH:0]   sp);
        if (sp[WIDTH]) return raw;
        return WIDTH'({1'b0, lo} + ({1'b0, raw} % sp));
    endfunction

    assign span = {1'b0, high_q} - {1'b0, low_q} + (WIDTH+1)'(1);
    assign base = (32'(r_q) * MAX_DIM + 32'(c_q)) * WIDTH;
    assign fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign last = (r_q == rows_q - DIM_W'(1)) && (c_q == cols_q - DIM_W'(1));

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        r_d      = r_q;
        c_d      = c_q;
        low_d    = low_q;
        high_d   = high_q;
        matrix_d = matrix_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
`ifdef RMG_ELEM_STREAM_EN
        elem_valid_d = 1'b0;
        elem_idx_d   = elem_idx_q;
        elem_data_d  = elem_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.seed_load)
                    lfsr_d = (bus.seed == 16'h0000) ? SEED : bus.seed;
                if (bus.start) begin
                    rows_d   = clamp_dim(bus.rows);
                    cols_d   = clamp_dim(bus.cols);
                    low_d    = (bus.min_val > bus.max_val) ? bus.max_val : bus.min_val;
                    high_d   = (bus.min_val > bus.max_val) ? bus.min_val : bus.max_val;
                    matrix_d = '0;
                    valid_d  = 1'b0;
                    r_d      = '0;
                    c_d      = '0;
                    busy_d   = 1'b1;
                    state_d  = S_FILL;
                end
            end
            default: begin
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    matrix_d[base +: WIDTH] = elem_value(lfsr_q[WIDTH-1:0], low_q, span);
                    lfsr_d = {lfsr_q[14:0], fb};
`ifdef RMG_ELEM_STREAM_EN
                    elem_valid_d = 1'b1;
                    elem_idx_d   = {r_q, c_q};
                    elem_data_d  = elem_value(lfsr_q[WIDTH-1:0], low_q, span);
`endif
                    if (c_q == cols_q - DIM_W'(1)) begin
                        c_d = '0;
                        r_d = r_q + DIM_W'(1);
                    end else begin
                        c_d = c_q + DIM_W'(1);
                    end
                    if (last) begin
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED;
            rows_q   <= '0;
            cols_q   <= '0;
            r_q      <= '0;
            c_q      <= '0;
            low_q    <= '0;
            high_q   <= '0;
            matrix_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifdef RMG_ELEM_STREAM_EN
            elem_valid_q <= 1'b0;
            elem_idx_q   <= '0;
            elem_data_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            r_q      <= r_d;
            c_q      <= c_d;
            low_q    <= low_d;
            high_q   <= high_d;
            matrix_q <= matrix_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
`ifdef RMG_ELEM_STREAM_EN
            elem_valid_q <= elem_valid_d;
            elem_idx_q   <= elem_idx_d;
            elem_data_q  <= elem_data_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.valid       = valid_q;
    assign bus.matrix_flat = matrix_q;
`ifdef RMG_ELEM_STREAM_EN
    assign bus.elem_valid  = elem_valid_q;
    assign bus.elem_idx    = elem_idx_q;
    assign bus.elem_data   = elem_data_q;
`endif
endmodule

// File: tb/tb_random_matrix_filler.sv
// Bench for random_matrix_filler: directed and randomized fills against an
// arithmetic reference model of the LFSR sequence and value mapping.
module tb_random_matrix_filler;
    localparam int W  = 8;
    localparam int MD = 5;
    localparam int DW = 3;
    localparam int NE = MD * MD;
    localparam int MW = NE * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    random_matrix_filler_if #(.WIDTH(W), .MAX_DIM(MD)) bus();
    random_matrix_filler #(.WIDTH(W), .MAX_DIM(MD), .SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [15:0]   m_lfsr;
    logic [MW-1:0] exp_mat;
    logic [MW-1:0] saved_mat;
`ifdef RMG_ELEM_STREAM_EN
    logic [2*DW+W-1:0] stream_q[$];
`endif

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic chk_mat(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic do_seed(input logic [15:0] sd);
        bus.seed_load = 1'b1;
        bus.seed      = sd;
        @(negedge clk);
        bus.seed_load = 1'b0;
        m_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
    endtask

    task automatic do_fill(input string tag, input int r, input int c, input int mn, input int mx,
                           input bit with_seed, input logic [15:0] sd,
                           input int abort_at, input bit disturb);
        int rr, cc, lo, hi, span, n, nw, row, col, val;
        int busy_cnt, done_cnt, done_at, k, got;
        logic [7:0] raw;
        rr   = (r < 1) ? 1 : ((r > MD) ? MD : r);
        cc   = (c < 1) ? 1 : ((c > MD) ? MD : c);
        lo   = (mn < mx) ? mn : mx;
        hi   = (mn < mx) ? mx : mn;
        span = hi - lo + 1;
        n    = rr * cc;
        nw   = (abort_at > 0) ? abort_at - 1 : n;
        if (with_seed) m_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
        exp_mat = '0;
        for (int i = 0; i < nw; i++) begin
            row = i / cc;
            col = i % cc;
            raw = m_lfsr[7:0];
            val = (span == 256) ? int'(raw) : lo + (int'(raw) % span);
            exp_mat[(row*MD+col)*W +: W] = val[7:0];
`ifdef RMG_ELEM_STREAM_EN
            stream_q.push_back({row[2:0], col[2:0], val[7:0]});
`endif
            m_lfsr = lfsr_next(m_lfsr);
        end

        bus.start   = 1'b1;
        bus.rows    = DW'(r);
        bus.cols    = DW'(c);
        bus.min_val = W'(mn);
        bus.max_val = W'(mx);
        if (with_seed) begin
            bus.seed_load = 1'b1;
            bus.seed      = sd;
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        chk({tag, "_busy_start"}, 64'(bus.busy), 64'd1);

        busy_cnt = 0; done_cnt = 0; done_at = -1; k = 0; got = 0;
        while (bus.busy && k < 200) begin
            busy_cnt++;
            k++;
            if (k == abort_at) bus.abort = 1'b1;
            if (disturb && k == 2) begin
                bus.start = 1'b1; bus.rows = 3'd5; bus.cols = 3'd5;
                bus.min_val = 8'd0; bus.max_val = 8'd0;
            end
            if (disturb && k == 3) begin
                bus.seed_load = 1'b1; bus.seed = 16'h1234;
            end
            @(negedge clk);
            bus.abort = 1'b0; bus.start = 1'b0; bus.seed_load = 1'b0;
            if (bus.done) begin done_cnt++; done_at = k; end
`ifdef RMG_ELEM_STREAM_EN
            if (bus.elem_valid) begin
                got++;
                if (stream_q.size() > 0)
                    chk({tag, "_elem"}, 64'({bus.elem_idx, bus.elem_data}), 64'(stream_q.pop_front()));
            end
`endif
        end
        chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'((abort_at > 0) ? abort_at : n));
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'((abort_at > 0) ? 0 : 1));
        if (abort_at == 0) chk({tag, "_done_at"}, 64'(done_at), 64'(n));
        chk({tag, "_valid"}, 64'(bus.valid), 64'((abort_at > 0) ? 0 : 1));
        chk_mat({tag, "_matrix"}, bus.matrix_flat, exp_mat);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
`ifdef RMG_ELEM_STREAM_EN
        chk({tag, "_elem_cnt"}, 64'(got), 64'(nw));
        chk({tag, "_elem_valid_end"}, 64'(bus.elem_valid), 64'd0);
        stream_q.delete();
`endif
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.rows = '0; bus.cols = '0;
        bus.min_val = '0; bus.max_val = '0; bus.seed_load = 1'b0; bus.seed = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk_mat("rst_matrix", bus.matrix_flat, '0);
`ifdef RMG_ELEM_STREAM_EN
        chk("rst_elem", 64'({bus.elem_valid, bus.elem_idx, bus.elem_data}), 64'd0);
`endif
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        @(negedge clk);

        do_seed(16'h0001);
        do_fill("t1", 2, 3, 0, 255, 1'b0, 16'h0, 0, 1'b0);
        chk("t1_e0", 64'(bus.matrix_flat[0*W +: W]), 64'h01);
        chk("t1_e5", 64'(bus.matrix_flat[5*W +: W]), 64'h08);
        chk("t1_e7", 64'(bus.matrix_flat[7*W +: W]), 64'h20);

        bus.abort = 1'b1;
        saved_mat = bus.matrix_flat;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("idle_abort_valid", 64'(bus.valid), 64'd1);
        chk_mat("idle_abort_matrix", bus.matrix_flat, saved_mat);

        do_fill("t2", 1, 4, 10, 3, 1'b1, 16'h0001, 0, 1'b0);
        chk("t2_e3", 64'(bus.matrix_flat[3*W +: W]), 64'd3);

        do_fill("t3", 0, 7, 0, 255, 1'b0, 16'h0, 0, 1'b0);

        do_seed(16'h0001);
        do_fill("t4", 2, 3, 0, 255, 1'b0, 16'h0, 0, 1'b1);
        chk("t4_e7", 64'(bus.matrix_flat[7*W +: W]), 64'h20);

        do_seed(16'h0001);
        do_fill("t5", 2, 3, 0, 255, 1'b0, 16'h0, 3, 1'b0);
        chk("t5_e1", 64'(bus.matrix_flat[1*W +: W]), 64'h02);
        chk("t5_e2", 64'(bus.matrix_flat[2*W +: W]), 64'h00);
        do_fill("t5_resume", 1, 2, 0, 255, 1'b0, 16'h0, 0, 1'b0);

        bus.start = 1'b1; bus.rows = 3'd5; bus.cols = 3'd5;
        bus.min_val = 8'd0; bus.max_val = 8'd255;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_valid", 64'(bus.valid), 64'd0);
        chk_mat("midrst_matrix", bus.matrix_flat, '0);
`ifdef RMG_ELEM_STREAM_EN
        chk("midrst_elem", 64'({bus.elem_valid, bus.elem_idx, bus.elem_data}), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        @(negedge clk);
        do_fill("post_rst", 2, 2, 0, 255, 1'b0, 16'h0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [15:0] sd;
            int mn, mx;
            sd = (i == 0) ? 16'h0000 : 16'($urandom);
            mn = $urandom_range(0, 255);
            mx = $urandom_range(0, 255);
            if (i == 1) begin mn = 0; mx = 255; end
            if (i % 2 == 0) do_seed(sd);
            do_fill("rnd", $urandom_range(0, 7), $urandom_range(0, 7), mn, mx,
                    (i % 2 == 1), sd, (i == 3) ? 1 : 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
